// File: rtl/vram_scanout.sv
// Frame scanout engine: reads 4bpp packed bytes from VRAM and streams them out
// as a valid/ready pixel stream with x/y coordinates and line/frame markers.
module vram_scanout #(
  parameter int LINES      = 128,
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic [12:0] vram_addr,
  input  logic [7:0]  vram_data,
  output logic [3:0]  pix,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [6:0]  pix_x,
  output logic [6:0]  pix_y,
  output logic        line_end,
  output logic        frame_end,
  output logic [1:0]  state_dbg
);

  localparam logic [1:0]  IDLE      = 2'd0;
  localparam logic [1:0]  FETCH     = 2'd1;
  localparam logic [1:0]  DRAIN     = 2'd2;
  localparam int          PW        = (FIFO_DEPTH > 2) ? 2 : 1;
  localparam logic [12:0] LAST_ADDR = 13'(LINES * 64 - 1);
  localparam logic [6:0]  LAST_LINE = 7'(LINES - 1);
  localparam logic [2:0]  DEPTH     = 3'(FIFO_DEPTH);

  logic [1:0]    state;
  logic [12:0]   next_addr;
  logic [12:0]   last_addr;
  logic          in_flight;
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [2:0]    count;
  logic          half;
  logic [7:0]    head;
  logic          issue;
  logic          pop;
  logic          hs;
  logic          last_pix;

  // Reads are credited against FIFO space before issue, so the one-cycle
  // VRAM latency can never overflow the byte buffer.
  assign issue     = (state == FETCH) && ((count + {2'b00, in_flight}) < DEPTH);
  // The address only moves when a read is actually issued; otherwise it
  // keeps showing the last byte read.
  assign vram_addr = issue ? next_addr : last_addr;

  // Pixel stream: a pixel transfers on any rising edge where pix_valid and
  // pix_ready are both high; while pix_valid is high and pix_ready is low,
  // pix/pix_x/pix_y hold, and pix_valid never drops without a transfer.
  assign head      = fifo_mem[rd_ptr];
  assign pix_valid = (count != 3'd0);
  assign hs        = pix_valid && pix_ready;
  assign pop       = hs && half;
  assign pix       = pix_valid ? (half ? head[7:4] : head[3:0]) : 4'd0;
  assign last_pix  = hs && (pix_x == 7'd127) && (pix_y == LAST_LINE);
  assign line_end  = pix_valid && (pix_x == 7'd127);
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (in_flight) fifo_mem[wr_ptr] <= vram_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      next_addr <= 13'd0;
      last_addr <= 13'd0;
      in_flight <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= 3'd0;
      half      <= 1'b0;
      pix_x     <= 7'd0;
      pix_y     <= 7'd0;
      frame_end <= 1'b0;
    end else begin
      in_flight <= issue;
      frame_end <= (state == DRAIN) && last_pix;

      case (state)
        IDLE: begin
          if (start) begin
            state     <= FETCH;
            next_addr <= 13'd0;
          end
        end
        FETCH: begin
          if (issue) begin
            last_addr <= next_addr;
            next_addr <= next_addr + 13'd1;
            if (next_addr == LAST_ADDR) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (last_pix) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (in_flight) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (in_flight && !pop) count <= count + 3'd1;
      else if (pop && !in_flight) count <= count - 3'd1;

      if (hs) begin
        half  <= ~half;
        pix_x <= pix_x + 7'd1;
        if (pix_x == 7'd127) pix_y <= (pix_y == LAST_LINE) ? 7'd0 : pix_y + 7'd1;
      end
    end
  end

endmodule

// File: tb/tb_vram_scanout.sv
// Bench for vram_scanout: a full 128-line instance and a 2-line/4-deep
// instance share one VRAM image; a scoreboard checks every pixel handshake.
module tb_vram_scanout;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        sel;
  logic        f_start, f_ready, s_start, s_ready;
  logic        f_busy, s_busy, f_valid, s_valid;
  logic        f_le, s_le, f_fe, s_fe;
  logic [12:0] f_addr, s_addr;
  logic [7:0]  f_vdata, s_vdata;
  logic [3:0]  f_pix, s_pix;
  logic [6:0]  f_x, f_y, s_x, s_y;
  logic [1:0]  f_state, s_state;

  logic [7:0]  mem [8192];
  logic [17:0] exp_q [$];
  int          checks = 0;
  int          errors = 0;
  int          hs_cnt = 0;
  int          fe_cnt = 0;

  vram_scanout #(.LINES(128), .FIFO_DEPTH(2)) u_full (
    .clk(clk), .rst(rst), .start(f_start), .busy(f_busy), .vram_addr(f_addr),
    .vram_data(f_vdata), .pix(f_pix), .pix_valid(f_valid), .pix_ready(f_ready),
    .pix_x(f_x), .pix_y(f_y), .line_end(f_le), .frame_end(f_fe), .state_dbg(f_state)
  );

  vram_scanout #(.LINES(2), .FIFO_DEPTH(4)) u_small (
    .clk(clk), .rst(rst), .start(s_start), .busy(s_busy), .vram_addr(s_addr),
    .vram_data(s_vdata), .pix(s_pix), .pix_valid(s_valid), .pix_ready(s_ready),
    .pix_x(s_x), .pix_y(s_y), .line_end(s_le), .frame_end(s_fe), .state_dbg(s_state)
  );

  // VRAM models: data valid one cycle after the address
  always @(posedge clk) begin
    f_vdata <= mem[f_addr];
    s_vdata <= mem[s_addr];
  end

  logic       m_valid, m_ready, m_le, m_fe, m_busy;
  logic [3:0] m_pix;
  logic [6:0] m_x, m_y;
  assign m_valid = sel ? s_valid : f_valid;
  assign m_ready = sel ? s_ready : f_ready;
  assign m_le    = sel ? s_le    : f_le;
  assign m_fe    = sel ? s_fe    : f_fe;
  assign m_busy  = sel ? s_busy  : f_busy;
  assign m_pix   = sel ? s_pix   : f_pix;
  assign m_x     = sel ? s_x     : f_x;
  assign m_y     = sel ? s_y     : f_y;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic set_in(input logic st, input logic rd);
    if (sel) begin
      s_start = st; s_ready = rd;
    end else begin
      f_start = st; f_ready = rd;
    end
  endtask

  task automatic push_frame(input int lines);
    for (int b = 0; b < lines * 64; b++) begin
      logic [6:0] x, y;
      logic [7:0] d;
      x = 7'((b % 64) * 2);
      y = 7'(b / 64);
      d = mem[b];
      exp_q.push_back({y, x, d[3:0]});
      exp_q.push_back({y, x + 7'd1, d[7:4]});
    end
  endtask

  task automatic check_reset();
    check("rst_busy",      32'(f_busy),  32'd0);
    check("rst_valid",     32'(f_valid), 32'd0);
    check("rst_addr",      32'(f_addr),  32'd0);
    check("rst_pix",       32'(f_pix),   32'd0);
    check("rst_x",         32'(f_x),     32'd0);
    check("rst_y",         32'(f_y),     32'd0);
    check("rst_line_end",  32'(f_le),    32'd0);
    check("rst_frame_end", 32'(f_fe),    32'd0);
    check("rst_state",     32'(f_state), 32'd0);
  endtask

  // Monitor: stall stability, line_end, address range and scoreboard pops
  logic        prev_stall = 1'b0;
  logic [17:0] prev_item  = '0;
  always @(negedge clk) begin
    logic [17:0] cur;
    cur = {m_y, m_x, m_pix};
    if (!rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && m_valid) check("stall_hold", 32'(cur), 32'(prev_item));
      if (m_valid) check("line_end", 32'(m_le), 32'(m_x == 7'd127));
      if (sel) check("addr_range", 32'(s_addr <= 13'd127), 32'd1);
      if (m_fe) fe_cnt++;
      if (m_valid && m_ready) begin
        logic [31:0] exp;
        hs_cnt++;
        exp = (exp_q.size() > 0) ? 32'(exp_q.pop_front()) : 32'hFFFF_FFFF;
        check("pixel", 32'(cur), exp);
      end
      prev_stall = m_valid && !m_ready;
      prev_item  = cur;
    end
  end

  task automatic run_frame(input int lines, input int pct, input bit twice);
    int fe0, hs0, n, first, bubbles;
    fe0 = fe_cnt; hs0 = hs_cnt; n = 0; first = -1; bubbles = 0;
    @(posedge clk); #1;
    set_in(1'b1, 1'($urandom_range(0, 99) < pct));
    while (fe_cnt == fe0 && n < 40000) begin
      @(posedge clk); #1;
      n++;
      if (m_valid && first < 0) first = n;
      if (first >= 0 && !m_valid && m_busy) bubbles++;
      set_in(1'(twice && n == 8), 1'($urandom_range(0, 99) < pct));
    end
    set_in(1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("frame_end_count", 32'(fe_cnt - fe0), 32'd1);
    check("handshakes", 32'(hs_cnt - hs0), 32'(lines * 128));
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("busy_falls", 32'(m_busy), 32'd0);
    check("first_valid_latency", 32'(first >= 1 && first <= 4), 32'd1);
    if (pct == 100) check("bubbles", 32'(bubbles), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int hs_base, fe_before, n;
    logic [12:0] addr_mid;
    for (int i = 0; i < 8192; i++) mem[i] = 8'(i);
    rst = 1'b0; sel = 1'b0;
    f_start = 1'b0; f_ready = 1'b0; s_start = 1'b0; s_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // Full frame, ready always high, with a stray start pulse during fetch
    push_frame(128);
    run_frame(128, 100, 1'b1);

    // Two-line instance, 30% ready, odd byte at address 64
    sel = 1'b1;
    mem[64] = 8'h5A;
    push_frame(2);
    run_frame(2, 30, 1'b0);
    mem[64] = 8'h40;

    // Stall after start: only FIFO_DEPTH reads, first pixel held
    sel = 1'b0;
    mem[0] = 8'hC3;
    push_frame(128);
    hs_base = hs_cnt;
    @(posedge clk); #1;
    set_in(1'b1, 1'b0);
    @(posedge clk); #1;
    set_in(1'b0, 1'b0);
    repeat (40) @(posedge clk);
    #1;
    addr_mid = f_addr;
    repeat (10) @(posedge clk);
    #1;
    check("stall_addr_frozen", 32'(f_addr), 32'(addr_mid));
    check("stall_addr_depth", 32'(f_addr), 32'd1);
    check("stall_valid", 32'(f_valid), 32'd1);
    check("stall_pix", 32'(f_pix), 32'h3);
    check("stall_xy", 32'({f_y, f_x}), 32'd0);

    // Release and abort with reset after 300 pixels
    n = 0;
    while (hs_cnt - hs_base < 300 && n < 2000) begin
      set_in(1'b0, 1'b1);
      @(posedge clk); #1;
      n++;
    end
    check("hs_before_reset", 32'(hs_cnt - hs_base), 32'd300);
    fe_before = fe_cnt;
    rst = 1'b0;
    set_in(1'b0, 1'b0);
    @(posedge clk); #1;
    check_reset();
    exp_q.delete();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("no_frame_end_on_abort", 32'(fe_cnt), 32'(fe_before));

    // Restart must rescan from address 0
    push_frame(128);
    run_frame(128, 100, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
